// File: rtl/mips_reg_pkg.sv
// Shared types and helpers for the MIPS register file with scoreboard.
// Contents: sweep FSM state enum, zero-register address, depth derivation.
package mips_reg_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } sb_state_e;

  // Register 0 is hard-wired to zero
  localparam int unsigned ZERO_ADDR = 0;

  // Number of entries addressable by an addr_w-bit address
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Per-register pending bits for producers still in flight.
// Ports:
//   Clk, Reset_n        clock, async active-low reset
//   Enable              1 = normal operation; pending outputs forced low otherwise
//   Clr_All             clear every pending bit
//   Set_En / Set_Addr   mark a register pending (producer issued)
//   Ret_En / Ret_Addr   retire a pending register (result written)
//   Byp_En / Byp_Addr   raw write strobe/address used to mask same-cycle retirement
//   R_Addr_A/B          read addresses
//   R_Pend_A/B          addressed register has an outstanding producer
module mips_reg_scoreboard
  import mips_reg_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Enable,
  input  logic              Clr_All,
  input  logic              Set_En,
  input  logic [ADDR_W-1:0] Set_Addr,
  input  logic              Ret_En,
  input  logic [ADDR_W-1:0] Ret_Addr,
  input  logic              Byp_En,
  input  logic [ADDR_W-1:0] Byp_Addr,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic              R_Pend_A,
  output logic              R_Pend_B
);

  localparam int unsigned       DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next pending vector: clear-all dominates; set after retire so a new producer wins
  always_comb begin
    pend_d = pend_q;
    if (Clr_All) begin
      pend_d = '0;
    end else begin
      if (Ret_En) pend_d[Ret_Addr] = 1'b0;
      if (Set_En) pend_d[Set_Addr] = 1'b1;
    end
    pend_d[ZERO_ADDR] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pend_q <= '0;
    else          pend_q <= pend_d;
  end

  // A write landing this cycle hides the pending bit when its data is forwarded
  always_comb begin
    R_Pend_A = Enable && (R_Addr_A != ZADDR) && pend_q[R_Addr_A] &&
               !(BYPASS && Byp_En && (Byp_Addr == R_Addr_A));
    R_Pend_B = Enable && (R_Addr_B != ZADDR) && pend_q[R_Addr_B] &&
               !(BYPASS && Byp_En && (Byp_Addr == R_Addr_B));
  end

endmodule

// File: rtl/mips_reg_sb.sv
// MIPS general-purpose register file with pending scoreboard and sweep clear.
// Ports:
//   Clk, Reset_n             clock, async active-low reset
//   R_Addr_A/B, R_Data_A/B   combinational read ports (entry 0 reads zero)
//   R_Pend_A/B               addressed register awaits a producer
//   W_Addr, W_Data, Write_Reg write port; a write also retires the pending bit
//   Issue_En, Issue_Addr     mark a destination pending
//   Clear_Req                request a full clear via the sweep
//   Ready                    registered, 1 = normal operation
module mips_reg_sb
  import mips_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic              R_Pend_A,
  output logic              R_Pend_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  input  logic              Issue_En,
  input  logic [ADDR_W-1:0] Issue_Addr,
  input  logic              Clear_Req,
  output logic              Ready
);

  localparam int unsigned       DEPTH = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  sb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ready_q, ready_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_ok;
  logic              iss_ok;
  logic              clr_all;
  logic              idle;

  // Storage without reset so it can map onto distributed RAM
  logic [DATA_W-1:0] mem [DEPTH];

  // State, sweep pointer and Ready register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= SWEEP;
      ptr_q   <= FIRST;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Next state plus the single array write port: sweep zeroing or a user write
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_addr  = ptr_q;
    mem_wdata = '0;
    wr_ok     = 1'b0;
    iss_ok    = 1'b0;
    clr_all   = 1'b0;
    case (state_q)
      SWEEP: begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + FIRST;
        if (ptr_q == LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (Clear_Req) begin
          clr_all = 1'b1;
          state_d = SWEEP;
          ptr_d   = FIRST;
          ready_d = 1'b0;
        end else begin
          wr_ok     = Write_Reg && (W_Addr != ZADDR);
          iss_ok    = Issue_En && (Issue_Addr != ZADDR);
          mem_we    = wr_ok;
          mem_addr  = W_Addr;
          mem_wdata = W_Data;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  assign idle  = (state_q == IDLE);
  assign Ready = ready_q;

  // Read muxes: zero register, optional same-cycle forward, else stored entry
  always_comb begin
    R_Data_A = '0;
    R_Data_B = '0;
    if (idle && (R_Addr_A != ZADDR)) begin
      R_Data_A = (BYPASS && Write_Reg && (W_Addr == R_Addr_A)) ? W_Data : mem[R_Addr_A];
    end
    if (idle && (R_Addr_B != ZADDR)) begin
      R_Data_B = (BYPASS && Write_Reg && (W_Addr == R_Addr_B)) ? W_Data : mem[R_Addr_B];
    end
  end

  mips_reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_sb (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Enable   (idle),
    .Clr_All  (clr_all),
    .Set_En   (iss_ok),
    .Set_Addr (Issue_Addr),
    .Ret_En   (wr_ok),
    .Ret_Addr (W_Addr),
    .Byp_En   (Write_Reg),
    .Byp_Addr (W_Addr),
    .R_Addr_A (R_Addr_A),
    .R_Addr_B (R_Addr_B),
    .R_Pend_A (R_Pend_A),
    .R_Pend_B (R_Pend_B)
  );

endmodule

// File: tb/tb_mips_reg_sb.sv
// Scoreboard bench for mips_reg_sb: one BYPASS=1 and one BYPASS=0 instance share
// stimulus; each slot pushes the expected observation of both, a monitor checks them.
module tb_mips_reg_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic [AW-1:0] R_Addr_A, R_Addr_B, W_Addr, Issue_Addr;
  logic [DW-1:0] W_Data;
  logic          Write_Reg, Issue_En, Clear_Req;

  logic [DW-1:0] d1_ra, d1_rb, d0_ra, d0_rb;
  logic          d1_pa, d1_pb, d1_rdy, d0_pa, d0_pb, d0_rdy;

  always #5 Clk = ~Clk;

  mips_reg_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) u_dut_byp (
    .Clk(Clk), .Reset_n(Reset_n),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(d1_ra), .R_Data_B(d1_rb),
    .R_Pend_A(d1_pa), .R_Pend_B(d1_pb),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Issue_En(Issue_En), .Issue_Addr(Issue_Addr),
    .Clear_Req(Clear_Req), .Ready(d1_rdy)
  );

  mips_reg_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) u_dut_nobyp (
    .Clk(Clk), .Reset_n(Reset_n),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .R_Data_A(d0_ra), .R_Data_B(d0_rb),
    .R_Pend_A(d0_pa), .R_Pend_B(d0_pb),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Issue_En(Issue_En), .Issue_Addr(Issue_Addr),
    .Clear_Req(Clear_Req), .Ready(d0_rdy)
  );

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic        pa;
    logic        pb;
    logic        rdy;
  } obs_t;

  typedef struct {
    string name;
    obs_t  e1;
    obs_t  e0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(input logic [31:0] da, input logic [31:0] db,
                              input logic pa, input logic pb, input logic rdy);
    obs_t o;
    o.da = da; o.db = db; o.pa = pa; o.pb = pb; o.rdy = rdy;
    return o;
  endfunction

  task automatic push2(input string n, input obs_t e1, input obs_t e0);
    exp_t e;
    e.name = n; e.e1 = e1; e.e0 = e0;
    exp_q.push_back(e);
  endtask

  task automatic push1(input string n, input obs_t e);
    push2(n, e, e);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: inputs settle just after posedge, outputs are compared at negedge
  always @(negedge Clk) begin
    obs_t a1;
    obs_t a0;
    exp_t e;
    a1 = {d1_ra, d1_rb, d1_pa, d1_pb, d1_rdy};
    a0 = {d0_ra, d0_rb, d0_pa, d0_pb, d0_rdy};
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a1 !== e.e1) begin
        errors++;
        $display("FAIL %s byp1 got da=%h db=%h pa=%b pb=%b rdy=%b want da=%h db=%h pa=%b pb=%b rdy=%b",
                 e.name, a1.da, a1.db, a1.pa, a1.pb, a1.rdy,
                 e.e1.da, e.e1.db, e.e1.pa, e.e1.pb, e.e1.rdy);
      end
      checks++;
      if (a0 !== e.e0) begin
        errors++;
        $display("FAIL %s byp0 got da=%h db=%h pa=%b pb=%b rdy=%b want da=%h db=%h pa=%b pb=%b rdy=%b",
                 e.name, a0.da, a0.db, a0.pa, a0.pb, a0.rdy,
                 e.e0.da, e.e0.db, e.e0.pa, e.e0.pb, e.e0.rdy);
      end
    end
  end

  initial begin
    Reset_n = 1'b0; R_Addr_A = '0; R_Addr_B = '0; W_Addr = '0; W_Data = '0;
    Write_Reg = 1'b0; Issue_En = 1'b0; Issue_Addr = '0; Clear_Req = 1'b0;
    cyc(); cyc();

    // Reset and initial sweep: Ready exactly after edge 31
    push1("reset", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    Reset_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cyc();
      R_Addr_A = AW'(i);
      R_Addr_B = AW'(31 - i);
      push1("init_sweep", mk(32'h0, 32'h0, 1'b0, 1'b0, i == 31));
    end
    cyc();
    for (int a = 0; a < 32; a++) begin
      R_Addr_A = AW'(a);
      R_Addr_B = AW'(31 - a);
      push1("zero_read", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
      cyc();
    end

    // Write-to-read forwarding on r5
    Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'hDEADBEEF; R_Addr_A = 5'd5; R_Addr_B = 5'd0;
    push2("byp_same", mk(32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1), mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b0;
    push1("byp_next", mk(32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();

    // Writes to r0 are discarded
    Write_Reg = 1'b1; W_Addr = 5'd0; W_Data = 32'h12345678; R_Addr_A = 5'd0; R_Addr_B = 5'd0;
    push1("r0_same", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b0;
    push1("r0_after", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();

    // Pending bit on r7: issue, retire, re-issue, issue+write same edge
    Issue_En = 1'b1; Issue_Addr = 5'd7; R_Addr_A = 5'd7; R_Addr_B = 5'd5;
    push1("iss_same", mk(32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b0;
    push1("iss_pend", mk(32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b1; W_Addr = 5'd7; W_Data = 32'h11111111;
    push2("ret_same", mk(32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1),
                      mk(32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b0;
    push1("ret_after", mk(32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b1;
    push1("iss2_same", mk(32'h11111111, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b0;
    push1("iss2_pend", mk(32'h11111111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b1; Write_Reg = 1'b1; W_Data = 32'h22222222;
    push2("iss_wr_same", mk(32'h22222222, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1),
                         mk(32'h11111111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b0; Write_Reg = 1'b0;
    push1("iss_wr_after", mk(32'h22222222, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b1; W_Data = 32'h33333333;
    push2("ret2_same", mk(32'h33333333, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1),
                       mk(32'h22222222, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b0;
    push1("ret2_after", mk(32'h33333333, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1));
    cyc();

    // Clear request: r3 and r9 pending wiped, writes/issues during sweep ignored
    Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'hA5A5A5A5; R_Addr_A = 5'd3; R_Addr_B = 5'd9;
    push2("r3_same", mk(32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b1), mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();
    Write_Reg = 1'b0; Issue_En = 1'b1; Issue_Addr = 5'd9;
    push1("r3_iss9", mk(32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();
    Issue_En = 1'b0; Clear_Req = 1'b1; Write_Reg = 1'b1; W_Addr = 5'd4; W_Data = 32'hFFFFFFFF;
    push1("clr_req", mk(32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b1));
    cyc();
    Clear_Req = 1'b0; Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'hCAFEF00D;
    Issue_En = 1'b1; Issue_Addr = 5'd3;
    for (int i = 0; i <= 31; i++) begin
      if (i == 31) begin
        Write_Reg = 1'b0;
        Issue_En  = 1'b0;
      end
      push1("clr_sweep", mk(32'h0, 32'h0, 1'b0, 1'b0, i == 31));
      cyc();
    end
    R_Addr_A = 5'd4; R_Addr_B = 5'd5;
    push1("post_clr", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();

    // Reset at sweep edge 10 restarts the sweep from entry 1
    Clear_Req = 1'b1;
    push1("clr2_req", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
    cyc();
    Clear_Req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push1("clr2_sweep", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
      cyc();
    end
    Reset_n = 1'b0;
    push1("mid_reset", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    cyc();
    push1("mid_release", mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    Reset_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cyc();
      push1("restart_sweep", mk(32'h0, 32'h0, 1'b0, 1'b0, i == 31));
    end
    cyc();

    repeat (3) cyc();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_sb.md
# mips_reg_sb

Parametrised successor to the MIPS general-purpose register file: two combinational read ports, one write port, hard-wired zero register, optional write-to-read bypass, and a per-register pending (scoreboard) bit for results still in flight from multi-cycle units. Storage carries no reset. After reset, or on request, a sweep state machine clears it one entry per cycle, so the array maps to distributed RAM. The block sits in the decode stage and feeds operands and hazard flags to the issue logic.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries, entry 0 reads as zero
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns stored value
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- R_Addr_A, R_Addr_B  in  ADDR_W  read addresses
- R_Data_A, R_Data_B  out  DATA_W  read data
- R_Pend_A, R_Pend_B  out  1  addressed register has an outstanding producer
- W_Addr  in  ADDR_W  write address
- W_Data  in  DATA_W  write data
- Write_Reg  in  1  write enable; also retires the pending bit of W_Addr
- Issue_En  in  1  marks Issue_Addr pending (producer issued)
- Issue_Addr  in  ADDR_W  destination of issued producer
- Clear_Req  in  1  one-cycle request to zero all registers and pending bits
- Ready  out  1  registered; 1 = IDLE, normal operation

## Operation
- States: SWEEP, IDLE. Reset_n low forces SWEEP, sweep pointer = 1, all pending bits 0, Ready = 0.
- SWEEP: each edge writes 0 to entry[ptr], ptr+1. The edge writing DEPTH-1 moves to IDLE and sets Ready. Write_Reg, Issue_En and Clear_Req are ignored. R_Data_* = 0 and R_Pend_* = 0.
- IDLE + Clear_Req: next edge clears all pending bits, ptr = 1, enters SWEEP and drops Ready. A Write_Reg or Issue_En on that same edge is dropped.
- Read: R_Data_X = 0 if R_Addr_X = 0. Else, if BYPASS and Write_Reg and W_Addr = R_Addr_X, it is W_Data. Else it is entry[R_Addr_X].
- R_Pend_X = pend[R_Addr_X] and not (Write_Reg and W_Addr = R_Addr_X). The second term applies only when BYPASS = 1. Always 0 for address 0.
- Write (IDLE, Write_Reg, W_Addr ≠ 0): entry[W_Addr] ← W_Data and pend[W_Addr] ← 0 on the edge. Writes to address 0 are discarded.
- Issue (IDLE, Issue_En, Issue_Addr ≠ 0): pend[Issue_Addr] ← 1. Issue to an already-pending register leaves the bit at 1, with no count.
- Issue and Write to the same address on the same edge: set wins, bit ends at 1 (new producer supersedes). Data is still written.

## Timing
- Reads and R_Pend_* are combinational from addresses and state; write-to-read latency is 0 with BYPASS = 1 and 1 cycle with BYPASS = 0.
- After Reset_n rises, Ready goes high on rising edge DEPTH-1 (edge 31 for default).
- Clear_Req sampled at edge k: Ready = 0 after k; Ready = 1 after edge k+DEPTH-1.
- Reset mid-sweep restarts the sweep at entry 1.
- Ready, pending bits, state and ptr are reset. Array contents are undefined until the sweep completes.

## Structure
- Package mips_reg_pkg: state enum {SWEEP, IDLE}, ZERO_ADDR constant, DEPTH derivation function.
- Sub-module mips_reg_scoreboard: DEPTH-bit pending vector, set/clear/clear-all logic and the two R_Pend outputs. The top holds the array, sweep FSM and read muxes.

## Test plan
- Reset, then count edges until Ready → Ready = 1 exactly after edge 31, and reads of every address return 0.
- In IDLE, write 0xDEADBEEF to r5 while reading r5 on A: BYPASS=1 → R_Data_A = 0xDEADBEEF in the same cycle. BYPASS=0 → old value, then 0xDEADBEEF next cycle.
- Write 0x12345678 to r0, then read r0 on both ports → 0, R_Pend = 0.
- Issue r7, then read r7 → R_Pend_A = 1. Write r7 → pend cleared. Issue and write r7 on the same edge → R_Pend stays 1, data updated.
- Write r3 = 0xA5A5A5A5, then Clear_Req → Ready low for 31 edges, writes during the sweep ignored, and r3 reads 0 after Ready.
- Assert Reset_n low at sweep edge 10 → pointer restarts, and Ready rises 31 edges after release.
